// File: rtl/sadd_seq_if.sv
// Handshake, adder-control and status signals of the serial-adder sequencer.
// slave is the sequencer's view; master is the view of whatever surrounds it.
interface sadd_seq_if #(
  parameter int unsigned W = 8
);
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         add_pload;
  logic         add_enable;
  logic [W-1:0] add_adata;
  logic [W-1:0] add_bdata;
  logic [W-1:0] add_pout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         busy;
  logic [15:0]  op_count;

  modport slave (
    input  flush, in_valid, in_a, in_b, add_pout, out_ready,
    output in_ready, add_pload, add_enable, add_adata, add_bdata,
           out_valid, out_sum, busy, op_count
  );

  modport master (
    output flush, in_valid, in_a, in_b, add_pout, out_ready,
    input  in_ready, add_pload, add_enable, add_adata, add_bdata,
           out_valid, out_sum, busy, op_count
  );
endinterface

// File: rtl/sadd_seq.sv
// Sequencer for an external bit-serial adder: latches an operand pair, strobes a parallel
// load, enables NSTEP shift cycles, then captures the result into a one-entry output buffer.
module sadd_seq #(
  parameter int unsigned NSTEP = 8
) (
  input logic        clk,
  input logic        rst,
  sadd_seq_if.slave  bus
);

  localparam int unsigned CntW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NSTEP - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StCapture} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [NSTEP-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      op_count_q, op_count_d;
  logic             in_ready_w, accept, consume, cap_wr;

  // in_ready is gated by rst so it reads 0 throughout reset, not just after it.
  assign in_ready_w = (state_q == StIdle) && rst;
  assign accept     = bus.in_valid && in_ready_w && !bus.flush;
  assign consume    = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;
    cap_wr      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCapture: begin
        if (!out_valid_q || bus.out_ready) begin
          cap_wr  = 1'b1;
          sum_d   = bus.add_pout;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A capture landing in the same cycle as a consume keeps the buffer full.
    if (cap_wr) begin
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
    if (consume) begin
      op_count_d = op_count_q + 16'd1;
    end

    if (bus.flush) begin
      state_d     = StIdle;
      cnt_d       = '0;
      sum_d       = sum_q;
      out_valid_d = 1'b0;
      op_count_d  = op_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.add_pload  = (state_q == StLoad);
  assign bus.add_enable = (state_q == StShift);
  assign bus.add_adata  = a_q;
  assign bus.add_bdata  = b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sum    = sum_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.op_count   = op_count_q;

endmodule
